// File: rtl/spi_reg_bridge_pkg.sv
// Shared encodings for the SPI-to-register bridge: transaction widths, FSM
// states, command-byte field positions and per-width helpers.
package spi_reg_bridge_pkg;

  localparam int MAX_W      = 32;
  localparam int CMD_RW_BIT = 7;
  localparam int WIDTH_MSB  = 6;
  localparam int WIDTH_LSB  = 5;

  typedef enum logic [1:0] {
    W8   = 2'b00,
    W16  = 2'b01,
    W32  = 2'b10,
    WINV = 2'b11
  } width_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RWAIT,
    RDATA,
    DONE,
    IGNORE
  } state_e;

  function automatic logic [5:0] width_bits(input logic [1:0] w);
    case (w)
      W8:      return 6'd8;
      W16:     return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input logic [1:0] w);
    case (w)
      W8:      return 32'h0000_00FF;
      W16:     return 32'h0000_FFFF;
      W32:     return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Turns the synchronised SPI clock and chip select into single-cycle edge
// pulses; SCLK edges are only reported while chip select is asserted.
module spi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic spi_cs_n,
  input  logic spi_clk,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic sclk_q;
  logic cs_q;

  // NOTE: cs_q resets to the deasserted level so a select already low when
  // reset releases still produces a falling pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      sclk_q <= spi_clk;
      cs_q   <= spi_cs_n;
    end
  end

  assign sclk_rise = !spi_cs_n &  spi_clk & !sclk_q;
  assign sclk_fall = !spi_cs_n & !spi_clk &  sclk_q;
  assign cs_fall   = !spi_cs_n &  cs_q;
  assign cs_rise   =  spi_cs_n & !cs_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that decodes command/address/data frames into TinyQV
// peripheral register reads and writes.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [REG_W-1:0]  reg_data_o,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic              reg_addr_v,
  input  logic              reg_data_i_dv,
  output logic              reg_data_o_dv,
  output logic              reg_rw,
  output logic [1:0]        txn_width
);

  state_e           state;
  logic [5:0]       bit_cnt;
  logic [REG_W-1:0] rx_shift;
  logic [REG_W-1:0] tx_shift;

  logic             sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0]       rx_byte;
  logic [REG_W-1:0] rx_word;
  logic [REG_W-1:0] wmask;
  logic [5:0]       nbits;
  logic             dummy_done;

  spi_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .spi_cs_n  (spi_cs_n),
    .spi_clk   (spi_clk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  // Views of the shifter including the bit being sampled this cycle.
  assign rx_byte    = {rx_shift[6:0], spi_mosi};
  assign rx_word    = {rx_shift[REG_W-2:0], spi_mosi};
  assign nbits      = width_bits(txn_width);
  assign wmask      = REG_W'(width_mask(txn_width));
  assign dummy_done = sclk_fall && (bit_cnt == 6'd8);

  // NOTE: every register here is state, so all updates are non-blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      spi_miso      <= 1'b0;
      reg_addr      <= '0;
      reg_data_o    <= '0;
      reg_addr_v    <= 1'b0;
      reg_data_o_dv <= 1'b0;
      reg_rw        <= 1'b0;
      txn_width     <= 2'b00;
    end else begin
      reg_data_o_dv <= 1'b0;
      if (reg_addr_v && reg_data_i_dv) reg_addr_v <= 1'b0;

      if (!ena) begin
        state      <= IDLE;
        reg_addr_v <= 1'b0;
        spi_miso   <= 1'b0;
      end else if (cs_rise && state != IDLE) begin
        state      <= IDLE;
        reg_addr_v <= 1'b0;
        spi_miso   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
          end

          CMD: if (sclk_rise) begin
            rx_shift <= rx_word;
            bit_cnt  <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd7) begin
              bit_cnt <= '0;
              if (rx_byte[WIDTH_MSB:WIDTH_LSB] == WINV) begin
                state <= IGNORE;
              end else begin
                reg_rw    <= rx_byte[CMD_RW_BIT];
                txn_width <= rx_byte[WIDTH_MSB:WIDTH_LSB];
                state     <= ADDR;
              end
            end
          end

          ADDR: if (sclk_rise) begin
            rx_shift <= rx_word;
            bit_cnt  <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd7) begin
              bit_cnt  <= '0;
              reg_addr <= rx_byte[ADDR_W-1:0];
              if (reg_rw) begin
                state <= WDATA;
              end else begin
                state      <= RWAIT;
                reg_addr_v <= 1'b1;
                tx_shift   <= '1;
              end
            end
          end

          WDATA: if (sclk_rise) begin
            rx_shift <= rx_word;
            bit_cnt  <= bit_cnt + 6'd1;
            if (bit_cnt == nbits - 6'd1) begin
              reg_data_o    <= rx_word & wmask;
              reg_data_o_dv <= 1'b1;
              state         <= DONE;
            end
          end

          RWAIT: begin
            // Read data is left-justified so MISO always shifts from the top bit.
            if (reg_addr_v && reg_data_i_dv && !dummy_done)
              tx_shift <= (reg_data_i & wmask) << (REG_W - int'(nbits));
            if (sclk_rise) bit_cnt <= bit_cnt + 6'd1;
            if (dummy_done) begin
              state    <= RDATA;
              bit_cnt  <= '0;
              spi_miso <= tx_shift[REG_W-1];
              tx_shift <= tx_shift << 1;
            end
          end

          RDATA: begin
            if (sclk_fall) begin
              spi_miso <= tx_shift[REG_W-1];
              tx_shift <= tx_shift << 1;
            end
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == nbits - 6'd1) begin
                state    <= DONE;
                spi_miso <= 1'b0;
              end
            end
          end

          DONE, IGNORE: ;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: writes, fast/slow reads, abort, invalid
// width, back-to-back frames and asynchronous reset.
module tb_spi_reg_bridge;
  import spi_reg_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [5:0]  reg_addr;
  logic [31:0] reg_data_o;
  logic [31:0] reg_data_i = '0;
  logic        reg_addr_v;
  logic        reg_data_i_dv = 1'b0;
  logic        reg_data_o_dv;
  logic        reg_rw;
  logic [1:0]  txn_width;

  int vectors     = 0;
  int miscompares = 0;

  int          dv_count      = 0;
  int          addr_v_cycles = 0;
  logic [31:0] first_wdata   = '0;
  int          rd_delay      = -1;
  int          v_age         = 0;

  spi_reg_bridge #(.ADDR_W(6), .REG_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .spi_cs_n      (spi_cs_n),
    .spi_clk       (spi_clk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .reg_addr      (reg_addr),
    .reg_data_o    (reg_data_o),
    .reg_data_i    (reg_data_i),
    .reg_addr_v    (reg_addr_v),
    .reg_data_i_dv (reg_data_i_dv),
    .reg_data_o_dv (reg_data_o_dv),
    .reg_rw        (reg_rw),
    .txn_width     (txn_width)
  );

  always #5 clk = ~clk;

  // Strobe / request monitor.
  always @(negedge clk) begin
    if (reg_data_o_dv) begin
      if (dv_count == 0) first_wdata = reg_data_o;
      dv_count++;
    end
    if (reg_addr_v) addr_v_cycles++;
  end

  // Peripheral model: answers rd_delay cycles after the request rises (-1 = never).
  always @(negedge clk) begin
    reg_data_i_dv = 1'b0;
    if (reg_addr_v) begin
      v_age++;
      if (rd_delay >= 0 && v_age == rd_delay) reg_data_i_dv = 1'b1;
    end else begin
      v_age = 0;
    end
  end

  task automatic clear_mon();
    dv_count      = 0;
    addr_v_cycles = 0;
    first_wdata   = '0;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    m = spi_miso;
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic spi_xfer(input logic [31:0] tx, input int n, output logic [31:0] rx);
    logic m;
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx = {rx[30:0], m};
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic write_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [31:0] data, input int n);
    logic [31:0] rx;
    cs_low();
    spi_xfer({24'h0, cmd}, 8, rx);
    spi_xfer({24'h0, addr}, 8, rx);
    spi_xfer(data, n, rx);
    cs_high();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (reg_addr !== 6'h00) begin miscompares++; $display("FAIL rst_addr: got %h want 00", reg_addr); end
    vectors++; if (reg_data_o !== 32'h0) begin miscompares++; $display("FAIL rst_wdata: got %h want 0", reg_data_o); end
    vectors++; if ({reg_addr_v, reg_data_o_dv, reg_rw, spi_miso} !== 4'b0) begin miscompares++; $display("FAIL rst_flags: got %b want 0000", {reg_addr_v, reg_data_o_dv, reg_rw, spi_miso}); end
    vectors++; if (txn_width !== 2'b00) begin miscompares++; $display("FAIL rst_width: got %b want 00", txn_width); end
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want IDLE", dut.state); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write32();
    clear_mon();
    write_frame(8'hC0, 8'h05, 32'hDEADBEEF, 32);
    vectors++; if (dv_count !== 1) begin miscompares++; $display("FAIL w32_strobes: got %0d want 1", dv_count); end
    vectors++; if (reg_addr !== 6'h05) begin miscompares++; $display("FAIL w32_addr: got %h want 05", reg_addr); end
    vectors++; if (reg_rw !== 1'b1) begin miscompares++; $display("FAIL w32_rw: got %b want 1", reg_rw); end
    vectors++; if (txn_width !== 2'b10) begin miscompares++; $display("FAIL w32_width: got %b want 10", txn_width); end
    vectors++; if (reg_data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL w32_data: got %h want deadbeef", reg_data_o); end
    vectors++; if (addr_v_cycles !== 0) begin miscompares++; $display("FAIL w32_addr_v: got %0d cycles want 0", addr_v_cycles); end
  endtask

  task automatic test_write8();
    clear_mon();
    write_frame(8'h80, 8'h3F, 32'h000000A5, 8);
    vectors++; if (dv_count !== 1) begin miscompares++; $display("FAIL w8_strobes: got %0d want 1", dv_count); end
    vectors++; if (reg_data_o !== 32'h000000A5) begin miscompares++; $display("FAIL w8_data: got %h want 000000a5", reg_data_o); end
    vectors++; if (txn_width !== 2'b00) begin miscompares++; $display("FAIL w8_width: got %b want 00", txn_width); end
    vectors++; if (reg_addr !== 6'h3F) begin miscompares++; $display("FAIL w8_addr: got %h want 3f", reg_addr); end
  endtask

  task automatic test_read_fast();
    logic [31:0] rx;
    clear_mon();
    rd_delay   = 2;
    reg_data_i = 32'h1234ABCD;
    cs_low();
    spi_xfer(32'h20, 8, rx);
    spi_xfer(32'h12, 8, rx);
    spi_xfer(32'h00, 8, rx);
    spi_xfer(32'h0, 16, rx);
    vectors++; if (reg_addr_v !== 1'b0) begin miscompares++; $display("FAIL rdf_addr_v_low: got %b want 0", reg_addr_v); end
    cs_high();
    vectors++; if (rx[15:0] !== 16'hABCD) begin miscompares++; $display("FAIL rdf_miso: got %h want abcd", rx[15:0]); end
    vectors++; if (addr_v_cycles < 1) begin miscompares++; $display("FAIL rdf_addr_v_seen: got %0d cycles want >=1", addr_v_cycles); end
    vectors++; if ({reg_rw, txn_width, reg_addr} !== {1'b0, 2'b01, 6'h12}) begin miscompares++; $display("FAIL rdf_fields: got %b/%b/%h want 0/01/12", reg_rw, txn_width, reg_addr); end
    vectors++; if (dv_count !== 0) begin miscompares++; $display("FAIL rdf_strobes: got %0d want 0", dv_count); end
  endtask

  task automatic test_read_slow();
    logic [31:0] rx;
    clear_mon();
    rd_delay   = -1;
    reg_data_i = 32'h0;
    cs_low();
    spi_xfer(32'h40, 8, rx);
    spi_xfer(32'h07, 8, rx);
    spi_xfer(32'h00, 8, rx);
    spi_xfer(32'h0, 32, rx);
    vectors++; if (rx !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL rds_miso: got %h want ffffffff", rx); end
    vectors++; if (reg_addr_v !== 1'b1) begin miscompares++; $display("FAIL rds_addr_v_held: got %b want 1", reg_addr_v); end
    cs_high();
    vectors++; if (reg_addr_v !== 1'b0) begin miscompares++; $display("FAIL rds_addr_v_drop: got %b want 0", reg_addr_v); end
  endtask

  task automatic test_abort();
    clear_mon();
    write_frame(8'hC0, 8'h09, 32'h00000ABC, 12);
    vectors++; if (dv_count !== 0) begin miscompares++; $display("FAIL abort_strobes: got %0d want 0", dv_count); end
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL abort_state: got %0d want IDLE", dut.state); end
    vectors++; if (reg_data_o !== 32'h000000A5) begin miscompares++; $display("FAIL abort_data_kept: got %h want 000000a5", reg_data_o); end
    write_frame(8'h80, 8'h01, 32'h0000005A, 8);
    vectors++; if (dv_count !== 1) begin miscompares++; $display("FAIL abort_next_strobes: got %0d want 1", dv_count); end
    vectors++; if ({reg_addr, reg_data_o} !== {6'h01, 32'h0000005A}) begin miscompares++; $display("FAIL abort_next_write: got %h/%h want 01/0000005a", reg_addr, reg_data_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx;
    clear_mon();
    cs_low();
    spi_xfer(32'h80, 8, rx);
    spi_xfer(32'h2A, 8, rx);
    spi_xfer(32'h3C, 8, rx);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(32'h80, 8, rx);
    spi_xfer(32'h15, 8, rx);
    spi_xfer(32'hC3, 8, rx);
    cs_high();
    vectors++; if (dv_count !== 2) begin miscompares++; $display("FAIL b2b_strobes: got %0d want 2", dv_count); end
    vectors++; if (first_wdata !== 32'h0000003C) begin miscompares++; $display("FAIL b2b_first: got %h want 0000003c", first_wdata); end
    vectors++; if ({reg_addr, reg_data_o} !== {6'h15, 32'h000000C3}) begin miscompares++; $display("FAIL b2b_second: got %h/%h want 15/000000c3", reg_addr, reg_data_o); end
  endtask

  task automatic test_invalid_and_reset();
    logic [31:0] rx;
    clear_mon();
    rd_delay = 1;
    cs_low();
    spi_xfer(32'hE0, 8, rx);
    spi_xfer(32'h12345678, 32, rx);
    vectors++; if (dut.state !== IGNORE) begin miscompares++; $display("FAIL inv_state: got %0d want IGNORE", dut.state); end
    cs_high();
    vectors++; if (dv_count !== 0) begin miscompares++; $display("FAIL inv_strobes: got %0d want 0", dv_count); end
    vectors++; if (addr_v_cycles !== 0) begin miscompares++; $display("FAIL inv_addr_v: got %0d cycles want 0", addr_v_cycles); end
    // Mid-frame asynchronous reset while outputs carry non-zero values.
    cs_low();
    spi_xfer(32'hC0, 8, rx);
    spi_xfer(32'h05, 8, rx);
    spi_xfer(32'h0F, 8, rx);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++; if ({reg_addr, reg_data_o} !== 38'h0) begin miscompares++; $display("FAIL arst_data: got %h/%h want 0/0", reg_addr, reg_data_o); end
    vectors++; if ({reg_addr_v, reg_data_o_dv, reg_rw, txn_width, spi_miso} !== 6'b0) begin miscompares++; $display("FAIL arst_flags: got %b want 000000", {reg_addr_v, reg_data_o_dv, reg_rw, txn_width, spi_miso}); end
    spi_cs_n = 1'b1;
    spi_clk  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL arst_state: got %0d want IDLE", dut.state); end
  endtask

  initial begin
    test_reset();
    test_write32();
    test_write8();
    test_read_fast();
    test_read_slow();
    test_abort();
    test_back_to_back();
    test_invalid_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
